cskip_sub64_seq: RTL

Block-serial 64-bit subtractor computing diff = a − b as a + ~b + 1. Each cycle it processes one 4-bit block with carry-skip logic, so a full operation takes 16 cycles. It is the inverse-direction companion to the combinational carry-skip adders in the adder library. Valid/ready handshakes on both ends let it sit in a datapath between a producer and a consumer.

---
 rtl/cskip_pkg.sv | 13 +
 rtl/cskip_blk4.sv | 20 ++
 rtl/cskip_sub64_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/cskip_pkg.sv
// Shared constants and FSM state type for the carry-skip subtractor family.
package cskip_pkg;
    localparam int CSKIP_WIDTH = 64;
    localparam int CSKIP_BLK   = 4;
    localparam int CSKIP_NBLK  = CSKIP_WIDTH / CSKIP_BLK;
    localparam int CSKIP_CNTW  = $clog2(CSKIP_NBLK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/cskip_blk4.sv
// One carry-skip block: ripple sum plus a skip mux that forwards cin when every bit propagates.
// Purely combinational; the critical path is one block plus the mux.
module cskip_blk4
    import cskip_pkg::*;
#(
    parameter int W = CSKIP_BLK
) (
    input  logic [W-1:0] a_blk,
    input  logic [W-1:0] nb_blk,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         p
);
    logic rc;

    assign {rc, s} = {1'b0, a_blk} + {1'b0, nb_blk} + {{W{1'b0}}, cin};
    assign p       = &(a_blk ^ nb_blk);
    assign cout    = p ? cin : rc;
endmodule

// File: rtl/cskip_sub64_seq.sv
// Block-serial a - b (a + ~b + 1), one BLK-bit carry-skip block per cycle; result 16 cycles after acceptance.
// in_ready only in IDLE; result held in DONE until out_ready. Signed overflow output exists only with CSKIP_SUB_OVF_EN.
module cskip_sub64_seq
    import cskip_pkg::*;
#(
    parameter int WIDTH = CSKIP_WIDTH,
    parameter int BLK   = CSKIP_BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef CSKIP_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NBLK = WIDTH / BLK;
    localparam int CW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBLK - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] nb_sh;
    logic [BLK-1:0]   s;
    logic             cout;
    logic             p;
`ifdef CSKIP_SUB_OVF_EN
    logic             a_msb;
    logic             nb_msb;
`endif

    // Operands shift right so the block selected by cnt always sits in the low BLK bits.
    cskip_blk4 #(.W(BLK)) u_blk (
        .a_blk  (a_sh[BLK-1:0]),
        .nb_blk (nb_sh[BLK-1:0]),
        .cin    (carry),
        .s      (s),
        .cout   (cout),
        .p      (p)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            nb_sh <= '0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef CSKIP_SUB_OVF_EN
            ovf    <= 1'b0;
            a_msb  <= 1'b0;
            nb_msb <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        nb_sh <= ~b;
                        carry <= 1'b1;
                        cnt   <= '0;
                        diff  <= '0;
`ifdef CSKIP_SUB_OVF_EN
                        a_msb  <= a[WIDTH-1];
                        nb_msb <= ~b[WIDTH-1];
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Sum blocks enter at the top and walk down to their final position.
                    diff  <= {s, diff[WIDTH-1:BLK]};
                    a_sh  <= a_sh >> BLK;
                    nb_sh <= nb_sh >> BLK;
                    carry <= cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        bout  <= ~cout;
`ifdef CSKIP_SUB_OVF_EN
                        // Operand signs differ exactly when a_msb equals the inverted b sign.
                        ovf   <= (a_msb == nb_msb) & (s[BLK-1] != a_msb);
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
